// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: eight requesters share one slot, grant held until done,
// withdrawal, or MAX_HOLD cycles. The pointer moves past each grantee on release.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    // state   | meaning
    // S_IDLE  | no grant held; next requester found from ptr is granted
    // S_GRANT | one requester owns the slot; release checked every cycle
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    logic [0:0] state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;

    logic       found;
    logic [2:0] win;
    logic [2:0] cand;
    logic       rel_user;
    logic       rel_limit;

    // Rotating search: first set request at ptr, ptr+1, ... wrapping at 8.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        cand  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        rel_user    = done | ~req[gnt_idx_q];
        rel_limit   = (hold_cnt_q == HOLD_LIMIT);
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_GRANT;
                    gnt_d       = 8'b1 << win;
                    gnt_idx_d   = win;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 8'd1;
                end
            end
            S_GRANT: begin
                if (rel_user || rel_limit) begin
                    state_d     = S_IDLE;
                    gnt_d       = 8'h00;
                    gnt_idx_d   = 3'd0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = 8'd0;
                    ptr_d       = gnt_idx_q + 3'd1;
                    // Pulse only when the hold limit alone forced the release.
                    timeout_d   = rel_limit & ~rel_user;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= 8'd0;
            gnt_q       <= 8'h00;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
